// File: rtl/selector_41_if.sv
// Bus bundle for the 4:1 selector: data inputs, select pair, load enable
// and the steered/decoded outputs. The clock and reset stay as plain ports.
interface selector_41_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] iC0;
  logic [WIDTH-1:0] iC1;
  logic [WIDTH-1:0] iC2;
  logic [WIDTH-1:0] iC3;
  logic             iS1;
  logic             iS0;
  logic             iEn;
  logic [WIDTH-1:0] oZ;
  logic [WIDTH-1:0] oZReg;
  logic [3:0]       oSelOH;
  logic             oSelChg;

  // Driver side: the environment that feeds data and select.
  modport master (
    output iC0, iC1, iC2, iC3, iS1, iS0, iEn,
    input  oZ, oZReg, oSelOH, oSelChg
  );

  // Selector side.
  modport slave (
    input  iC0, iC1, iC2, iC3, iS1, iS0, iEn,
    output oZ, oZReg, oSelOH, oSelChg
  );
endinterface

// File: rtl/selector_41.sv
// 4:1 selector for WIDTH-bit words. Combinational steered output, a
// registered copy with load enable, a one-hot select decode and a
// one-cycle pulse flagging a select change.

// Single-bit steering slice; one instance per data bit.
module selector_41_lane (
  input  logic [3:0] c_i,
  input  logic [1:0] sel_i,
  output logic       z_o
);
  assign z_o = c_i[sel_i];
endmodule

module selector_41 #(
  parameter int WIDTH = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  selector_41_if.slave bus
);
  logic [1:0]       sel;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] zReg_q, zReg_d;
  logic [1:0]       selPrev_q, selPrev_d;
  logic             selChg_q, selChg_d;

  assign sel = {bus.iS1, bus.iS0};

  // Per-bit slices; each gathers its bit from the four data words.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    selector_41_lane u_lane (
      .c_i   ({bus.iC3[g], bus.iC2[g], bus.iC1[g], bus.iC0[g]}),
      .sel_i (sel),
      .z_o   (z[g])
    );
  end

  // Next-state: load on enable, track select every cycle, flag differences.
  always_comb begin
    zReg_d    = bus.iEn ? z : zReg_q;
    selPrev_d = sel;
    selChg_d  = (sel != selPrev_q);
  end

  // State registers; reset wins over enable and over a concurrent select change.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      zReg_q    <= '0;
      selPrev_q <= 2'b00;
      selChg_q  <= 1'b0;
    end else begin
      zReg_q    <= zReg_d;
      selPrev_q <= selPrev_d;
      selChg_q  <= selChg_d;
    end
  end

  assign bus.oZ      = z;
  assign bus.oSelOH  = 4'b0001 << sel;
  assign bus.oZReg   = zReg_q;
  assign bus.oSelChg = selChg_q;
endmodule

// File: tb/tb_selector_41.sv
// Scoreboard bench for selector_41: a reference model pushes the expected
// registered outputs per clock edge; each scenario pops and compares.
module tb_selector_41;
  localparam int W = 4;

  logic iClk = 1'b0;
  logic iRst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [W-1:0] z;
    logic         chg;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] m_z;
  logic [1:0]   m_prev;
  logic [3:0]   oh_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  selector_41_if #(.WIDTH(W)) bus ();

  selector_41 #(.WIDTH(W)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  function automatic logic [W-1:0] ref_mux(logic [1:0] s);
    case (s)
      2'b00:   return bus.iC0;
      2'b01:   return bus.iC1;
      2'b10:   return bus.iC2;
      default: return bus.iC3;
    endcase
  endfunction

  // Advance the model one edge, queue its prediction, then step the DUT.
  task automatic tick();
    logic [1:0] s;
    exp_t x;
    s = {bus.iS1, bus.iS0};
    if (iRst) begin
      m_z = '0; x.chg = 1'b0; m_prev = 2'b00;
    end else begin
      if (bus.iEn) m_z = ref_mux(s);
      x.chg = (s != m_prev);
      m_prev = s;
    end
    x.z = m_z;
    sb.push_back(x);
    @(posedge iClk);
    #1;
  endtask

  task automatic set_sel(logic [1:0] s);
    {bus.iS1, bus.iS0} = s;
  endtask

  task automatic test_reset();
    iRst = 1'b1; bus.iEn = 1'b0; set_sel(2'b00);
    bus.iC0 = 4'b0101; bus.iC1 = 4'b1010; bus.iC2 = 4'b0000; bus.iC3 = 4'b1111;
    m_z = '0; m_prev = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (bus.oZReg !== e.z || bus.oZReg !== 4'b0000) begin
        errors++; $display("FAIL reset_zreg: got %b exp %b", bus.oZReg, e.z);
      end
      checks++;
      if (bus.oSelChg !== 1'b0) begin
        errors++; $display("FAIL reset_selchg: got %b exp 0", bus.oSelChg);
      end
    end
  endtask

  // Combinational path while reset is held: oZ/oSelOH must still follow.
  task automatic test_comb();
    logic [1:0]   sels [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [W-1:0] zs   [4] = '{4'b0101, 4'b1010, 4'b1111, 4'b0000};
    logic [W-1:0] cq[$];
    logic [3:0]   oq[$];
    logic [W-1:0] ez;
    logic [3:0]   eo;
    for (int i = 0; i < 4; i++) begin
      set_sel(sels[i]);
      cq.push_back(zs[i]);
      oq.push_back(oh_tab[sels[i]]);
      #20;
      ez = cq.pop_front();
      eo = oq.pop_front();
      checks++;
      if (bus.oZ !== ez) begin
        errors++; $display("FAIL comb_oz sel=%b: got %b exp %b", sels[i], bus.oZ, ez);
      end
      checks++;
      if (bus.oSelOH !== eo) begin
        errors++; $display("FAIL comb_onehot sel=%b: got %b exp %b", sels[i], bus.oSelOH, eo);
      end
    end
  endtask

  task automatic test_reg_load();
    iRst = 1'b1; bus.iEn = 1'b1; set_sel(2'b11);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) iRst = 1'b0;
      tick();
      e = sb.pop_front();
      checks++;
      if (bus.oZReg !== e.z) begin
        errors++; $display("FAIL load_zreg cyc=%0d: got %b exp %b", i, bus.oZReg, e.z);
      end
      checks++;
      if (bus.oSelChg !== e.chg) begin
        errors++; $display("FAIL load_selchg cyc=%0d: got %b exp %b", i, bus.oSelChg, e.chg);
      end
    end
    checks++;
    if (bus.oZReg !== 4'b1111) begin
      errors++; $display("FAIL load_value: got %b exp 1111", bus.oZReg);
    end
  endtask

  task automatic test_hold();
    bus.iEn = 1'b0; set_sel(2'b01);
    #1;
    checks++;
    if (bus.oZ !== 4'b1010) begin
      errors++; $display("FAIL hold_oz_immediate: got %b exp 1010", bus.oZ);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.iEn = 1'b1;
      tick();
      e = sb.pop_front();
      checks++;
      if (bus.oZReg !== e.z) begin
        errors++; $display("FAIL hold_zreg cyc=%0d: got %b exp %b", i, bus.oZReg, e.z);
      end
      checks++;
      if (bus.oSelChg !== e.chg) begin
        errors++; $display("FAIL hold_selchg cyc=%0d: got %b exp %b", i, bus.oSelChg, e.chg);
      end
    end
  endtask

  task automatic test_selchg();
    logic [1:0] seq [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      set_sel(seq[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if (bus.oSelChg !== e.chg || bus.oSelChg !== pat[i]) begin
        errors++; $display("FAIL selchg_pulse cyc=%0d: got %b exp %b", i, bus.oSelChg, pat[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.iEn = 1'b1; set_sel(2'b11); iRst = 1'b1;
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.oZReg !== 4'b0000 || bus.oZReg !== e.z) begin
      errors++; $display("FAIL midrst_zreg: got %b exp 0000", bus.oZReg);
    end
    checks++;
    if (bus.oSelChg !== 1'b0) begin
      errors++; $display("FAIL midrst_selchg: got %b exp 0", bus.oSelChg);
    end
    iRst = 1'b0;
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.oSelChg !== e.chg || bus.oSelChg !== 1'b1) begin
      errors++; $display("FAIL midrst_release_chg: got %b exp 1", bus.oSelChg);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      iRst    = ($urandom_range(0, 9) == 0);
      bus.iEn = $urandom_range(0, 1) == 1;
      bus.iC0 = W'($urandom); bus.iC1 = W'($urandom);
      bus.iC2 = W'($urandom); bus.iC3 = W'($urandom);
      set_sel(2'($urandom_range(0, 3)));
      #1;
      checks++;
      if (bus.oZ !== ref_mux({bus.iS1, bus.iS0}) || bus.oSelOH !== oh_tab[{bus.iS1, bus.iS0}]) begin
        errors++; $display("FAIL rand_comb %0d: oz %b oh %b", i, bus.oZ, bus.oSelOH);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (bus.oZReg !== e.z || bus.oSelChg !== e.chg) begin
        errors++; $display("FAIL rand_reg %0d: got %b/%b exp %b/%b", i, bus.oZReg, bus.oSelChg, e.z, e.chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_reg_load();
    test_hold();
    test_selchg();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
